// File: rtl/hamming_pkg.sv
// Shared constants, FSM states and the SECDED encoder for the ECC memory bank.
// Codeword bit index equals Hamming position; bit 0 carries overall parity.
package hamming_pkg;
   localparam int CW_WIDTH = 13;
   localparam int DATA_W   = 8;

   // DATA_POS[i] is the codeword position of data bit i; PAR_POS[p] holds check bit p.
   localparam logic [7:0][3:0] DATA_POS = {4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3};
   localparam logic [3:0][3:0] PAR_POS  = {4'd8, 4'd4, 4'd2, 4'd1};

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DECODE, ST_SCRUB} state_t;

   function automatic logic [CW_WIDTH-1:0] hamming_encode(input logic [DATA_W-1:0] d);
      logic [CW_WIDTH-1:0] cw;
      logic                par;
      cw = '0;
      for (int i = 0; i < DATA_W; i++) cw[DATA_POS[i]] = d[i];
      // Check-bit positions are still zero here, so each parity sees data bits only.
      for (int p = 0; p < 4; p++) begin
         par = 1'b0;
         for (int b = 1; b < CW_WIDTH; b++) if (b[p]) par ^= cw[b];
         cw[PAR_POS[p]] = par;
      end
      cw[0] = ^cw[CW_WIDTH-1:1];
      return cw;
   endfunction
endpackage

// File: rtl/hamming_secded_decoder.sv
// Combinational SECDED decode: corrected data, rewritable codeword and SEC/DED flags.
module hamming_secded_decoder
   import hamming_pkg::*;
(
   input  logic [CW_WIDTH-1:0] cw,
   output logic [DATA_W-1:0]   data,
   output logic [CW_WIDTH-1:0] cw_fixed,
   output logic                sec,
   output logic                ded
);
   logic [3:0]          syn;
   logic                par;
   logic [CW_WIDTH-1:0] flipped;

   always_comb begin
      syn = '0;
      for (int b = 1; b < CW_WIDTH; b++) if (cw[b]) syn ^= b[3:0];
      par     = ^cw;
      flipped = cw;
      sec     = 1'b0;
      ded     = 1'b0;
      if (par) begin
         if (syn == 4'd0) begin
            flipped[0] = ~cw[0];
            sec        = 1'b1;
         end else if (syn <= 4'd12) begin
            flipped[syn] = ~cw[syn];
            sec          = 1'b1;
         end else begin
            ded = 1'b1;
         end
      end else if (syn != 4'd0) begin
         ded = 1'b1;
      end
      // On DED nothing was flipped, so data comes back uncorrected.
      data = '0;
      for (int i = 0; i < DATA_W; i++) data[i] = flipped[DATA_POS[i]];
      cw_fixed = sec ? hamming_encode(data) : cw;
   end
endmodule

// File: rtl/hamming_bank.sv
// One ECC bank: SECDED-encoded storage, read/decode/scrub FSM and saturating error counter.
module hamming_bank
   import hamming_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-3:0] i_address,
   input  logic [DATA_W-1:0]     i_data,
   input  logic [CW_WIDTH-1:0]   i_inject,
   output logic [DATA_W-1:0]     o_data,
   output logic                  o_valid,
   output logic                  o_sec,
   output logic                  o_ded,
   output logic                  o_busy,
   output logic [CNT_WIDTH-1:0]  o_err_count
);
   localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

   logic [CW_WIDTH-1:0]   mem [DEPTH];
   state_t                state;
   logic [ADDR_WIDTH-3:0] addr_q;
   logic [CW_WIDTH-1:0]   cw_q;

   logic [DATA_W-1:0]     dec_data;
   logic [CW_WIDTH-1:0]   dec_cw;
   logic                  dec_sec, dec_ded;

   logic                  mem_we;
   logic [ADDR_WIDTH-3:0] mem_wa;
   logic [CW_WIDTH-1:0]   mem_wd;

   hamming_secded_decoder u_dec (
      .cw       (cw_q),
      .data     (dec_data),
      .cw_fixed (dec_cw),
      .sec      (dec_sec),
      .ded      (dec_ded)
   );

   // cw_q is untouched in SCRUB, so the decoder still presents the corrected word there.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = i_address;
      mem_wd = hamming_encode(i_data) ^ i_inject;
      if (!i_rst) begin
         if (state == ST_IDLE && i_en && i_wr_en) begin
            mem_we = 1'b1;
         end else if (state == ST_SCRUB) begin
            mem_we = 1'b1;
            mem_wa = addr_q;
            mem_wd = dec_cw;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_sec       <= 1'b0;
         o_ded       <= 1'b0;
         o_err_count <= '0;
      end else begin
         o_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (i_en && !i_wr_en) begin
                  addr_q <= i_address;
                  state  <= ST_READ;
               end
            end
            ST_READ: begin
               cw_q  <= mem[addr_q];
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               o_data  <= dec_data;
               o_sec   <= dec_sec;
               o_ded   <= dec_ded;
               o_valid <= 1'b1;
               if ((dec_sec || dec_ded) && o_err_count != {CNT_WIDTH{1'b1}})
                  o_err_count <= o_err_count + 1'b1;
               state <= dec_sec ? ST_SCRUB : ST_IDLE;
            end
            ST_SCRUB: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy = (state != ST_IDLE);
endmodule

// File: doc/hamming_bank.md
# hamming_bank

Single ECC-protected memory bank, one of four placed directly downstream of the bank address demultiplexer. Stores 8-bit data as 13-bit SECDED Hamming codewords and decodes them on read. Corrects single-bit errors and scrubs the corrected word back into memory. Detects double-bit errors, flags each event, and keeps a saturating count of error events.

## Interface
- `ADDR_WIDTH`, default 4: top-level address width; bank address is `ADDR_WIDTH-2` bits, depth `2**(ADDR_WIDTH-2)`.
- `CNT_WIDTH`, default 8: error event counter width.
- `i_clk`, input, 1: clock; all state changes on the rising edge.
- `i_rst`, input, 1: reset; **one clock; reset is synchronous and active-high**.
- `i_en`, input, 1: bank selected (decoded top address bits); a request is present when high.
- `i_wr_en`, input, 1: 1 = write, 0 = read; sampled with `i_en`.
- `i_address`, input, `ADDR_WIDTH-2`: bank-local address from the demultiplexer output.
- `i_data`, input, 8: write data.
- `i_inject`, input, 13: error injection mask, XORed into the codeword on write (verification use; tie to 0).
- `o_data`, output, 8: corrected read data.
- `o_valid`, output, 1: one-cycle pulse, read result valid.
- `o_sec`, output, 1: single error corrected; qualified by `o_valid`.
- `o_ded`, output, 1: double error detected; qualified by `o_valid`.
- `o_busy`, output, 1: high whenever state is not IDLE; requests are ignored while high.
- `o_err_count`, output, `CNT_WIDTH`: saturating count of SEC plus DED events.

## Operation
- Codeword bit index equals Hamming position.
  - Parity bits are at positions 1, 2, 4, 8.
  - Data bits d0..d7 are at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Bit 0 is overall parity: XOR of bits 1..12.
- Syndrome `s` = XOR of the position indices of all set bits 1..12. Parity check `p` = XOR of all 13 bits.
- Decode outcomes:
  - `s=0`, `p=0`: clean.
  - `p=1`, `s=0`: bit 0 in error. SEC; data is unaffected.
  - `p=1`, `1<=s<=12`: flip bit `s`. SEC.
  - `p=1`, `s>12`: DED.
  - `p=0`, `s!=0`: DED. `o_data` returns the uncorrected data bits.
- States: IDLE, READ, DECODE, SCRUB.
- Transitions:
  - IDLE & `i_en` & `i_wr_en`: write the encoded codeword XOR `i_inject` at this edge. Stay in IDLE.
  - IDLE & `i_en` & !`i_wr_en`: latch the address and go to READ.
  - READ: register the memory codeword and go to DECODE.
  - DECODE: register `o_data`, `o_sec`, `o_ded`, `o_valid=1`, and update the counter. Go to SCRUB if SEC, else IDLE.
  - SCRUB: write the corrected codeword (fresh encode of corrected data) to the latched address. Go to IDLE.
- `i_en` while `o_busy`=1 is dropped, not queued.
- `o_err_count` increments by 1 per SEC or DED event. It holds at all-ones.
- The memory array is not reset. Reset leaves its contents intact.

## Timing
- Reset values: state IDLE; `o_data=0`, `o_valid=0`, `o_sec=0`, `o_ded=0`, `o_busy=0`, `o_err_count=0`.
- Write latency: one cycle. Data is readable by a read request issued in the next cycle.
- Read request sampled at the end of cycle N:
  - `o_busy` is high in N+1 and N+2 (and N+3 if scrubbing).
  - `o_valid` pulses in N+3.
  - `o_data`, `o_sec`, `o_ded` hold their values until the next DECODE.
- Back-to-back reads: the next request is accepted in cycle N+3 (no SEC) or N+4 (after SCRUB).
- Reset asserted in any state: the next state is IDLE and a pending scrub is cancelled. `o_valid` is 0 in the cycle after reset.
- Reset wins over a simultaneous request.

## Structure
- Package `hamming_pkg` holds:
  - `CW_WIDTH=13`;
  - the data-position and parity-position constants;
  - the state enum;
  - the `hamming_encode` function.
- Sub-module `hamming_secded_decoder` is combinational. It takes the codeword and produces corrected data, corrected codeword, `sec` and `ded`.
- `hamming_bank` holds the memory array, the FSM, the output registers and the counter.

## Test plan
- Write 0xA5 to address 2 with `i_inject=0`, then read address 2 → `o_valid` in N+3, `o_data=0xA5`, `o_sec=0`, `o_ded=0`, count stays 0.
- Write 0xA5 with `i_inject=13'h0008`, then read → `o_data=0xA5`, `o_sec=1`, count 1, SCRUB cycle observed. A second read returns `o_sec=0`.
- Write 0x3C with `i_inject=13'h0001`, then read → `o_data=0x3C`, `o_sec=1`. Inject `13'h0006` → `o_ded=1`, no scrub, a repeat read gives `o_ded=1` again, count +2.
- Read request, then `i_en` pulses in N+1 and N+2 → both ignored, exactly one `o_valid`. Reset asserted in N+2 → no `o_valid`, state IDLE, memory still returns the old data afterwards.
- 260 SEC-producing reads (re-inject an error before each) → `o_err_count` saturates at 255.
